axil_req_arbiter: RTL and testbench
===================================

// Module: axil_req_arbiter
// PURPOSE
//  Shares one AXI4-Lite master port between NUM_REQ local requesters issuing single-beat
//  register reads/writes (e.g. to the checkin_v2_0 S00_AXI register bank). Round-robin
//  grant, one transaction in flight, per-requester response pulse, sticky hang detect.
// PARAMETERS
//  NUM_REQ         2    number of requesters (>=2)
//  ADDR_WIDTH      4    AXI-Lite byte address width (4 x 32-bit regs)
//  DATA_WIDTH      32   data width; STRB_WIDTH = DATA_WIDTH/8
//  TIMEOUT_CYCLES  256  cycles waiting in one bus state before bus_hung sets (>=2)
// PORTS
//  clock           in   1              system clock
//  reset           in   1              synchronous, active-high
//  req_valid       in   NUM_REQ        per-requester command valid
//  req_ready       out  NUM_REQ        one-hot, 1-cycle command accept
//  req_write       in   NUM_REQ        1=write, 0=read
//  req_addr        in   NUM_REQ*AW     packed addresses, requester i at [i*AW +: AW]
//  req_wdata       in   NUM_REQ*DW     packed write data
//  req_wstrb       in   NUM_REQ*SW     packed write strobes
//  rsp_valid       out  NUM_REQ        one-hot, 1-cycle completion pulse, no backpressure
//  rsp_rdata       out  DW             read data (0 for writes), valid with rsp_valid
//  rsp_resp        out  2              BRESP/RRESP of completed transaction
//  bus_hung        out  1              sticky; cleared only by reset
//  m_axi_aw{addr,prot,valid} out AW/3/1; m_axi_awready in 1   write address channel
//  m_axi_w{data,strb,valid}  out DW/SW/1; m_axi_wready in 1   write data channel
//  m_axi_b{resp,valid} in 2/1; m_axi_bready out 1              write response channel
//  m_axi_ar{addr,prot,valid} out AW/3/1; m_axi_arready in 1   read address channel
//  m_axi_r{data,resp,valid} in DW/2/1; m_axi_rready out 1     read data channel
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all valid/ready/rsp outputs 0, rsp_rdata 0,
//   rsp_resp 0, bus_hung 0, timeout counter 0. awprot/arprot constant 3'b000.
//  Requester holds addr/data/write stable while req_valid until req_ready.
//  FSM: IDLE -> (any req_valid) accept: req_ready[g]=1 same cycle, cmd registered,
//   grant g = first valid at/after pointer; pointer <= g+1 mod NUM_REQ.
//   -> WR_AW_W (write) or RD_AR (read) next cycle.
//  WR_AW_W: awvalid,wvalid rise together; each drops independently after its handshake;
//   both done -> WR_B. WR_B: bready=1; on bvalid -> RESP with bresp, rdata 0.
//  RD_AR: arvalid until arready -> RD_R. RD_R: rready=1; on rvalid capture rdata,rresp -> RESP.
//  RESP: rsp_valid[g]=1 one cycle, -> IDLE. No grant in RESP; next accept earliest cycle after.
//  Latency, zero-wait slave: accept cycle 0, AW/W or AR valid cycle 1, B/R handshake
//   cycle 2, rsp_valid cycle 3. Throughput: one transaction per 4 cycles minimum.
//  Timeout: counter clears on state change, increments each cycle in WR_AW_W/WR_B/RD_AR/RD_R;
//   at TIMEOUT_CYCLES sets bus_hung, saturates. FSM keeps waiting; valids never withdrawn
//   (AXI rule).
//  Simultaneous requests: only granted requester sees req_ready; others wait, no loss.
//  Reset mid-transaction: all channel valids/readies and rsp_valid drop at the reset edge;
//   slave shares reset, no response is delivered for the aborted command.
//  Non-OKAY bresp/rresp passed through unchanged; not an error inside this block.
// STRUCTURE
//  Package axil_arb_pkg: state enum (IDLE,WR_AW_W,WR_B,RD_AR,RD_R,RESP), RESP_OKAY=2'b00,
//   RESP_SLVERR=2'b10, AXI_PROT_DEFAULT=3'b000.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer in, one-hot grant + index out,
//   combinational; FSM, command regs and timeout stay in top.
// TESTING
//  1 req0 writes 1,2,3,4 to 0x0,0x4,0x8,0xC then reads back -> rsp_rdata 1..4, rsp_resp 00.
//  2 req0,req1 held valid for 8 writes -> grants 0,1,0,1..., each accept 4 cycles apart.
//  3 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid
//    held 4 cycles, exactly one bready handshake, one rsp_valid.
//  4 slave never asserts bvalid, TIMEOUT_CYCLES=16 -> bus_hung=1 16 cycles into WR_B,
//    bready stays 1, rsp_valid stays 0.
//  5 reset asserted while RD_R waiting -> next cycle arvalid=rready=rsp_valid=0; after
//    release, req1 and req0 both valid -> req0 granted (pointer 0).
//  6 slave returns rresp=SLVERR for 0x8 -> rsp_resp=2'b10, rsp_rdata = slave rdata.

Source files
------------

// File: rtl/axil_req_arbiter_pkg.sv
// Purpose: shared types and constants for the AXI4-Lite request arbiter.
//   arb_state_t      : bus-side FSM states
//   RESP_*           : AXI response codes seen on BRESP/RRESP
//   AXI_PROT_DEFAULT : fixed AxPROT value (unprivileged, secure, data)
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY        = 2'b00;
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_req_arbiter_if.sv
// Purpose: bundles the requester-side command/response signals and the
// AXI4-Lite master channels of the arbiter.
//   modport master : arbiter side (accepts commands, drives the AXI master port)
//   modport slave  : environment side (requesters + AXI-Lite slave)
interface axil_req_arbiter_if #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // requester side
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [1:0]                    rsp_resp;

  // AXI4-Lite channels
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;
  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [STRB_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]            m_axi_arprot;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata, rsp_resp,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axil_req_arbiter_rr.sv
// Purpose: combinational round-robin pick: first asserted request at or after
// the pointer, wrapping modulo NUM_REQ.
//   i_req : request vector        i_ptr : highest-priority index
//   o_gnt : one-hot grant         o_idx : granted index   o_any : any request
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int unsigned w_pos;

  // scan from the pointer; the first hit wins
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_pos = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (!o_any && i_req[IDX_W'(w_pos)]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(w_pos);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Purpose: shares one AXI4-Lite master port between NUM_REQ requesters with a
// round-robin grant, one transaction in flight, a one-cycle response pulse to
// the owner and a sticky hang flag when the slave stalls too long.
//   i_clock    : clock
//   i_reset    : synchronous, active-high reset
//   io_bus     : requester command/response + AXI4-Lite master channels
//   o_bus_hung : sticky, set after TIMEOUT_CYCLES in one bus wait state
module axil_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                i_clock,
  input  logic                i_reset,
  axil_req_arbiter_if.master  io_bus,
  output logic                o_bus_hung
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t            r_state,     w_state_nxt;
  logic [IDX_W-1:0]      r_ptr,       w_ptr_nxt;
  logic [IDX_W-1:0]      r_gidx,      w_gidx_nxt;
  logic [ADDR_WIDTH-1:0] r_addr,      w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata,     w_wdata_nxt;
  logic [STRB_WIDTH-1:0] r_wstrb,     w_wstrb_nxt;
  logic                  r_awvalid,   w_awvalid_nxt;
  logic                  r_wvalid,    w_wvalid_nxt;
  logic                  r_bready,    w_bready_nxt;
  logic                  r_arvalid,   w_arvalid_nxt;
  logic                  r_rready,    w_rready_nxt;
  logic [NUM_REQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]            r_rsp_resp,  w_rsp_resp_nxt;
  logic [CNT_W-1:0]      r_tcnt,      w_tcnt_nxt;
  logic                  r_hung,      w_hung_nxt;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gidx;
  logic                  w_any;
  logic [NUM_REQ-1:0]    w_req_ready;
  logic                  w_wait;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req (io_bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  // state and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
      r_tcnt      <= '0;
      r_hung      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gidx      <= w_gidx_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_resp  <= w_rsp_resp_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_hung      <= w_hung_nxt;
    end
  end

  // next-state, channel handshakes and hang detection
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gidx_nxt      = r_gidx;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_rsp_valid_nxt = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_resp_nxt  = r_rsp_resp;
    w_tcnt_nxt      = r_tcnt;
    w_hung_nxt      = r_hung;
    w_req_ready     = '0;
    w_wait          = 1'b0;

    case (r_state)
      IDLE: begin
        // no accept while reset is held: the command would be dropped
        if (w_any && !i_reset) begin
          w_req_ready = w_gnt;
          w_gidx_nxt  = w_gidx;
          w_ptr_nxt   = (w_gidx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gidx + IDX_W'(1);
          w_addr_nxt  = io_bus.req_addr[32'(w_gidx) * ADDR_WIDTH +: ADDR_WIDTH];
          w_wdata_nxt = io_bus.req_wdata[32'(w_gidx) * DATA_WIDTH +: DATA_WIDTH];
          w_wstrb_nxt = io_bus.req_wstrb[32'(w_gidx) * STRB_WIDTH +: STRB_WIDTH];
          if (io_bus.req_write[w_gidx]) begin
            w_state_nxt   = WR_AW_W;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt   = RD_AR;
            w_arvalid_nxt = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        w_wait = 1'b1;
        if (r_awvalid && io_bus.m_axi_awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && io_bus.m_axi_wready)   w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_state_nxt  = WR_B;
          w_bready_nxt = 1'b1;
        end
      end
      WR_B: begin
        w_wait = 1'b1;
        if (io_bus.m_axi_bvalid) begin
          w_bready_nxt            = 1'b0;
          w_state_nxt             = RESP;
          w_rsp_valid_nxt[r_gidx] = 1'b1;
          w_rsp_rdata_nxt         = '0;
          w_rsp_resp_nxt          = io_bus.m_axi_bresp;
        end
      end
      RD_AR: begin
        w_wait = 1'b1;
        if (io_bus.m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = RD_R;
        end
      end
      RD_R: begin
        w_wait = 1'b1;
        if (io_bus.m_axi_rvalid) begin
          w_rready_nxt            = 1'b0;
          w_state_nxt             = RESP;
          w_rsp_valid_nxt[r_gidx] = 1'b1;
          w_rsp_rdata_nxt         = io_bus.m_axi_rdata;
          w_rsp_resp_nxt          = io_bus.m_axi_rresp;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // per-state wait counter; saturates so the flag sets exactly once
    if (w_state_nxt != r_state) begin
      w_tcnt_nxt = '0;
    end else if (w_wait && (r_tcnt < CNT_W'(TIMEOUT_CYCLES))) begin
      w_tcnt_nxt = r_tcnt + CNT_W'(1);
    end
    w_hung_nxt = r_hung | (w_tcnt_nxt == CNT_W'(TIMEOUT_CYCLES));
  end

  assign io_bus.req_ready     = w_req_ready;
  assign io_bus.rsp_valid     = r_rsp_valid;
  assign io_bus.rsp_rdata     = r_rsp_rdata;
  assign io_bus.rsp_resp      = r_rsp_resp;
  assign io_bus.m_axi_awaddr  = r_addr;
  assign io_bus.m_axi_awprot  = AXI_PROT_DEFAULT;
  assign io_bus.m_axi_awvalid = r_awvalid;
  assign io_bus.m_axi_wdata   = r_wdata;
  assign io_bus.m_axi_wstrb   = r_wstrb;
  assign io_bus.m_axi_wvalid  = r_wvalid;
  assign io_bus.m_axi_bready  = r_bready;
  assign io_bus.m_axi_araddr  = r_addr;
  assign io_bus.m_axi_arprot  = AXI_PROT_DEFAULT;
  assign io_bus.m_axi_arvalid = r_arvalid;
  assign io_bus.m_axi_rready  = r_rready;
  assign o_bus_hung           = r_hung;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Purpose: directed self-checking bench for axil_req_arbiter with a small
// 4-register AXI4-Lite slave model (configurable AW delay, B/R suppression,
// SLVERR on address 0x8).
module tb_axil_req_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic hung;

  always #5 clk = ~clk;

  axil_req_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axil_req_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .io_bus     (bus),
    .o_bus_hung (hung)
  );

  // slave model knobs and state
  int          aw_delay;
  bit          b_en, r_en, slverr8;
  logic [31:0] mem [4];
  logic [31:0] aw_wait;
  logic        got_aw, got_w;
  logic [3:0]  aw_a;
  logic [31:0] w_d;
  logic        s_bvalid, s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  assign bus.m_axi_awready = bus.m_axi_awvalid && (aw_wait >= 32'(aw_delay));
  assign bus.m_axi_wready  = 1'b1;
  assign bus.m_axi_arready = 1'b1;
  assign bus.m_axi_bvalid  = s_bvalid;
  assign bus.m_axi_bresp   = 2'b00;
  assign bus.m_axi_rvalid  = s_rvalid;
  assign bus.m_axi_rdata   = s_rdata;
  assign bus.m_axi_rresp   = s_rresp;

  wire        aw_hs   = bus.m_axi_awvalid && bus.m_axi_awready;
  wire        w_hs    = bus.m_axi_wvalid && bus.m_axi_wready;
  wire        aw_done = got_aw | aw_hs;
  wire        w_done  = got_w | w_hs;
  wire [3:0]  wa      = aw_hs ? bus.m_axi_awaddr : aw_a;
  wire [31:0] wd      = w_hs ? bus.m_axi_wdata : w_d;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait  <= 0;
      got_aw   <= 1'b0;
      got_w    <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
    end else begin
      if (bus.m_axi_awvalid && !bus.m_axi_awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_done && w_done) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        mem[wa[3:2]] <= wd;
        if (b_en) s_bvalid <= 1'b1;
      end else begin
        if (aw_hs) begin got_aw <= 1'b1; aw_a <= bus.m_axi_awaddr; end
        if (w_hs)  begin got_w  <= 1'b1; w_d  <= bus.m_axi_wdata;  end
      end
      if (s_bvalid && bus.m_axi_bready) s_bvalid <= 1'b0;
      if (bus.m_axi_arvalid && bus.m_axi_arready && r_en) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[bus.m_axi_araddr[3:2]];
        s_rresp  <= (slverr8 && bus.m_axi_araddr == 4'h8) ? 2'b10 : 2'b00;
      end
      if (s_rvalid && bus.m_axi_rready) s_rvalid <= 1'b0;
    end
  end

  // monitor
  int cyc = 0;
  bit mon_clr;
  int rsp_cnt0, rsp_cnt1, aw_cyc, w_cyc, b_hs;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      rsp_cnt0 <= 0; rsp_cnt1 <= 0; aw_cyc <= 0; w_cyc <= 0; b_hs <= 0;
    end else begin
      if (bus.rsp_valid[0]) rsp_cnt0 <= rsp_cnt0 + 1;
      if (bus.rsp_valid[1]) rsp_cnt1 <= rsp_cnt1 + 1;
      if (bus.m_axi_awvalid) aw_cyc <= aw_cyc + 1;
      if (bus.m_axi_wvalid)  w_cyc  <= w_cyc + 1;
      if (bus.m_axi_bvalid && bus.m_axi_bready) b_hs <= b_hs + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_cmd(input int i, input bit wr, input logic [3:0] a, input logic [31:0] d);
    bus.req_write[i]          = wr;
    bus.req_addr[i*4 +: 4]    = a;
    bus.req_wdata[i*32 +: 32] = d;
    bus.req_wstrb[i*4 +: 4]   = 4'hF;
  endtask

  // waits (bounded) for req_ready[i]; returns accept cycle in c0
  task automatic wait_accept(input string tag, input int i, output int c0);
    bit seen;
    seen = 1'b0;
    c0 = cyc;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (bus.req_ready[i]) begin
        seen = 1'b1;
        c0 = cyc;
      end else begin
        step(); settle();
      end
    end
    chk({tag, "_accept"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_ready_onehot"}, 32'(bus.req_ready), 32'd1 << i);
  endtask

  // one complete transaction for requester i
  task automatic xact(input string tag, input int i, input bit wr, input logic [3:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic [1:0] rs,
                      output int lat);
    int c0;
    bit seen;
    set_cmd(i, wr, a, d);
    bus.req_valid[i] = 1'b1;
    settle();
    wait_accept(tag, i, c0);
    step();
    bus.req_valid[i] = 1'b0;
    settle();
    seen = 1'b0;
    lat = -1;
    rd = 'x;
    rs = 'x;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (bus.rsp_valid != 2'b00) begin
        seen = 1'b1;
        lat  = cyc - c0;
        rd   = bus.rsp_rdata;
        rs   = bus.rsp_resp;
        chk({tag, "_rsp_onehot"}, 32'(bus.rsp_valid), 32'd1 << i);
      end else begin
        step(); settle();
      end
    end
    chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    step(); settle();
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          lat, c0, g, last, n0, n1;
  logic [1:0]  gv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0;
    aw_delay = 0; b_en = 1'b1; r_en = 1'b1; slverr8 = 1'b0; mon_clr = 1'b1;
    for (int k = 0; k < 4; k++) mem[k] = 32'h0;
    repeat (3) step();
    rst = 1'b0; mon_clr = 1'b0;
    settle();

    // reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_resp",  32'(bus.rsp_resp), 32'd0);
    chk("rst_awvalid",   32'(bus.m_axi_awvalid), 32'd0);
    chk("rst_wvalid",    32'(bus.m_axi_wvalid), 32'd0);
    chk("rst_arvalid",   32'(bus.m_axi_arvalid), 32'd0);
    chk("rst_bready",    32'(bus.m_axi_bready), 32'd0);
    chk("rst_rready",    32'(bus.m_axi_rready), 32'd0);
    chk("rst_hung",      32'(hung), 32'd0);
    chk("rst_awprot",    32'(bus.m_axi_awprot), 32'd0);
    chk("rst_arprot",    32'(bus.m_axi_arprot), 32'd0);

    // 1: write 1..4 to 0x0..0xC, read back
    for (int k = 0; k < 4; k++) begin
      xact("t1_wr", 0, 1'b1, 4'(k * 4), 32'(k + 1), rd, rs, lat);
      chk("t1_wr_lat", 32'(lat), 32'd3);
      chk("t1_wr_resp", 32'(rs), 32'd0);
      chk("t1_wr_rdata", rd, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      xact("t1_rd", 0, 1'b0, 4'(k * 4), 32'h0, rd, rs, lat);
      chk("t1_rd_lat", 32'(lat), 32'd3);
      chk("t1_rd_resp", 32'(rs), 32'd0);
      chk("t1_rd_rdata", rd, 32'(k + 1));
    end

    // 6: SLVERR on 0x8 passes through with the slave's data
    slverr8 = 1'b1;
    xact("t6", 1, 1'b0, 4'h8, 32'h0, rd, rs, lat);
    chk("t6_resp", 32'(rs), 32'h2);
    chk("t6_rdata", rd, 32'd3);
    chk("t6_lat", 32'(lat), 32'd3);
    slverr8 = 1'b0;

    // 2: both requesters held valid for 8 writes (pointer is 0 after req1)
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    set_cmd(0, 1'b1, 4'h0, 32'h100);
    set_cmd(1, 1'b1, 4'h4, 32'h200);
    bus.req_valid = 2'b11;
    settle();
    n0 = 0; n1 = 0; g = 0; last = 0;
    for (int t = 0; t < 80 && g < 8; t++) begin
      if (bus.req_ready != 2'b00) begin
        gv = bus.req_ready;
        chk("t2_grant", 32'(gv), (g % 2 == 0) ? 32'd1 : 32'd2);
        if (g > 0) chk("t2_spacing", 32'(cyc - last), 32'd4);
        last = cyc;
        g++;
        step();
        if (gv[0]) begin
          n0++;
          if (n0 == 4) bus.req_valid[0] = 1'b0;
          else bus.req_wdata[31:0] = 32'h100 + 32'(n0);
        end
        if (gv[1]) begin
          n1++;
          if (n1 == 4) bus.req_valid[1] = 1'b0;
          else bus.req_wdata[63:32] = 32'h200 + 32'(n1);
        end
        settle();
      end else begin
        step(); settle();
      end
    end
    chk("t2_grants", 32'(g), 32'd8);
    for (int t = 0; t < 20 && !(rsp_cnt0 == 4 && rsp_cnt1 == 4); t++) begin
      step(); settle();
    end
    chk("t2_rsp0", 32'(rsp_cnt0), 32'd4);
    chk("t2_rsp1", 32'(rsp_cnt1), 32'd4);
    xact("t2_rb0", 0, 1'b0, 4'h0, 32'h0, rd, rs, lat);
    chk("t2_rb0_data", rd, 32'h103);
    xact("t2_rb1", 1, 1'b0, 4'h4, 32'h0, rd, rs, lat);
    chk("t2_rb1_data", rd, 32'h203);

    // 3: awready delayed 3 cycles, wready immediate
    aw_delay = 3;
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    xact("t3", 0, 1'b1, 4'h4, 32'hA5, rd, rs, lat);
    chk("t3_lat", 32'(lat), 32'd6);
    chk("t3_resp", 32'(rs), 32'd0);
    chk("t3_aw_cycles", 32'(aw_cyc), 32'd4);
    chk("t3_w_cycles", 32'(w_cyc), 32'd1);
    chk("t3_b_handshakes", 32'(b_hs), 32'd1);
    chk("t3_rsp0", 32'(rsp_cnt0), 32'd1);
    chk("t3_rsp1", 32'(rsp_cnt1), 32'd0);
    aw_delay = 0;

    // 4: no B response -> bus_hung 16 cycles into WR_B
    b_en = 1'b0;
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    set_cmd(0, 1'b1, 4'h0, 32'h77);
    bus.req_valid[0] = 1'b1;
    settle();
    wait_accept("t4", 0, c0);
    step();
    bus.req_valid[0] = 1'b0;
    settle();
    for (int t = 0; t < 40 && cyc < c0 + 17; t++) begin
      step(); settle();
    end
    chk("t4_hung_before", 32'(hung), 32'd0);
    chk("t4_bready_before", 32'(bus.m_axi_bready), 32'd1);
    step(); settle();
    chk("t4_hung_set", 32'(hung), 32'd1);
    chk("t4_bready", 32'(bus.m_axi_bready), 32'd1);
    repeat (10) step();
    settle();
    chk("t4_hung_sticky", 32'(hung), 32'd1);
    chk("t4_bready_held", 32'(bus.m_axi_bready), 32'd1);
    chk("t4_no_rsp", 32'(rsp_cnt0 + rsp_cnt1), 32'd0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0; b_en = 1'b1;
    settle();
    chk("t4_hung_cleared", 32'(hung), 32'd0);
    chk("t4_bready_cleared", 32'(bus.m_axi_bready), 32'd0);

    // 5: reset while RD_R waits, then pointer back at 0
    r_en = 1'b0;
    mon_clr = 1'b1; step(); mon_clr = 1'b0;
    set_cmd(0, 1'b0, 4'h0, 32'h0);
    bus.req_valid[0] = 1'b1;
    settle();
    wait_accept("t5", 0, c0);
    step();
    bus.req_valid[0] = 1'b0;
    settle();
    for (int t = 0; t < 20 && cyc < c0 + 4; t++) begin
      step(); settle();
    end
    chk("t5_rready_wait", 32'(bus.m_axi_rready), 32'd1);
    chk("t5_arvalid_wait", 32'(bus.m_axi_arvalid), 32'd0);
    rst = 1'b1;
    set_cmd(0, 1'b1, 4'hC, 32'h66);
    set_cmd(1, 1'b1, 4'h8, 32'h55);
    bus.req_valid = 2'b11;
    step(); settle();
    chk("t5_arvalid_rst", 32'(bus.m_axi_arvalid), 32'd0);
    chk("t5_rready_rst", 32'(bus.m_axi_rready), 32'd0);
    chk("t5_rsp_valid_rst", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0; r_en = 1'b1;
    settle();
    chk("t5_grant_ptr0", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid[0] = 1'b0;
    settle();
    for (int t = 0; t < 30; t++) begin
      if (bus.req_ready[1]) begin
        step(); bus.req_valid[1] = 1'b0; settle();
      end else begin
        step(); settle();
      end
    end
    chk("t5_rsp0", 32'(rsp_cnt0), 32'd1);
    chk("t5_rsp1", 32'(rsp_cnt1), 32'd1);
    chk("t5_mem_c", mem[3], 32'h66);
    chk("t5_mem_8", mem[2], 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
